// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: cpu-style address/data strobes in,
// tagged read data, acknowledge and status flags out.
interface mem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  logic [DATA_W-1:0] ad;
  logic [TAG_W-1:0]  tag;
  logic              astb;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] rdata;
  logic [TAG_W-1:0]  rtag;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (output ad, tag, astb, rd, wr, input rdata, rtag, ack, busy, err);
  modport slave  (input ad, tag, astb, rd, wr, output rdata, rtag, ack, busy, err);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous tagged memory.
// Each port latches its strobed request; one access is sequenced at a time.
module mem_arbiter_port #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ad,
  input  logic [TAG_W-1:0]  tag,
  input  logic              astb,
  input  logic              rd,
  input  logic              wr,
  input  logic              ack_set,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [TAG_W-1:0]  cap_tag,
  output logic [ADDR_W-1:0] addr,
  output logic              op,
  output logic [DATA_W-1:0] wdata,
  output logic [TAG_W-1:0]  wtag,
  output logic              pend,
  output logic              err,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [TAG_W-1:0]  rtag
);
  logic bad;

  // The ack cycle is the only window where a new strobe may overlap a pending request.
  assign bad = (astb & wr) | (rd & wr) | ((astb | rd | wr) & pend & ~ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      op    <= 1'b0;
      wdata <= '0;
      wtag  <= '0;
      pend  <= 1'b0;
      err   <= 1'b0;
      ack   <= 1'b0;
      rdata <= '0;
      rtag  <= '0;
    end else begin
      ack <= ack_set;
      if (cap) begin
        rdata <= cap_data;
        rtag  <= cap_tag;
      end
      if (ack) pend <= 1'b0;
      if (bad) begin
        err <= 1'b1;
      end else begin
        if (astb) addr <= ad[ADDR_W-1:0];
        // Later assignment lets a new request in the ack cycle win over the clear.
        if (rd | wr) begin
          pend <= 1'b1;
          op   <= wr;
        end
        if (wr) begin
          wdata <= ad;
          wtag  <= tag;
        end
      end
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      c,
  mem_arbiter_if.slave      d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [TAG_W-1:0]  mem_wtag,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [TAG_W-1:0]  mem_rtag
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t state;
  logic   gnt;
  logic   last_grant;
  logic   sel;

  logic [NP-1:0][DATA_W-1:0] ad_a;
  logic [NP-1:0][TAG_W-1:0]  tag_a;
  logic [NP-1:0]             astb_a, rd_a, wr_a;
  logic [NP-1:0][ADDR_W-1:0] addr_a;
  logic [NP-1:0]             op_a, pend_a, err_a, ack_a;
  logic [NP-1:0][DATA_W-1:0] wdata_a, rdata_a;
  logic [NP-1:0][TAG_W-1:0]  wtag_a, rtag_a;
  logic [NP-1:0]             ack_set, cap;

  assign ad_a   = {d.ad, c.ad};
  assign tag_a  = {d.tag, c.tag};
  assign astb_a = {d.astb, c.astb};
  assign rd_a   = {d.rd, c.rd};
  assign wr_a   = {d.wr, c.wr};

  assign c.rdata = rdata_a[0];
  assign c.rtag  = rtag_a[0];
  assign c.ack   = ack_a[0];
  assign c.busy  = pend_a[0];
  assign c.err   = err_a[0];
  assign d.rdata = rdata_a[1];
  assign d.rtag  = rtag_a[1];
  assign d.ack   = ack_a[1];
  assign d.busy  = pend_a[1];
  assign d.err   = err_a[1];

  for (genvar i = 0; i < NP; i++) begin : g_port
    mem_arbiter_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .ad       (ad_a[i]),
      .tag      (tag_a[i]),
      .astb     (astb_a[i]),
      .rd       (rd_a[i]),
      .wr       (wr_a[i]),
      .ack_set  (ack_set[i]),
      .cap      (cap[i]),
      .cap_data (mem_rdata),
      .cap_tag  (mem_rtag),
      .addr     (addr_a[i]),
      .op       (op_a[i]),
      .wdata    (wdata_a[i]),
      .wtag     (wtag_a[i]),
      .pend     (pend_a[i]),
      .err      (err_a[i]),
      .ack      (ack_a[i]),
      .rdata    (rdata_a[i]),
      .rtag     (rtag_a[i])
    );
  end

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    sel = pend_a[1];
    if (pend_a[0] & pend_a[1]) sel = ~last_grant;
  end

  // Port registers ack one cycle later, so it lands in RESP.
  always_comb begin
    ack_set = '0;
    cap     = '0;
    if ((state == ACCESS && mem_we) || state == CAPTURE) ack_set[gnt] = 1'b1;
    if (state == CAPTURE) cap[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wtag   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend_a) begin
            gnt       <= sel;
            mem_addr  <= addr_a[sel];
            mem_wdata <= wdata_a[sel];
            mem_wtag  <= wtag_a[sel];
            mem_re    <= ~op_a[sel];
            mem_we    <= op_a[sel];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= mem_we ? RESP : CAPTURE;
        end
        CAPTURE: state <= RESP;
        RESP: begin
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level model of both ports and the memory contents.
module tb_mem_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) c_if ();
  mem_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) d_if ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [TAG_W-1:0]  mem_wtag;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [TAG_W-1:0]  mem_rtag = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .c         (c_if),
    .d         (d_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wtag  (mem_wtag),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_rtag  (mem_rtag)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_re = 0;
  int n_we = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Initial memory contents, known to both the memory model and the reference model.
  function automatic logic [63:0] pat_d(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0001_0003_0007;
  endfunction
  function automatic logic [7:0] pat_t(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // Synchronous memory: 64 words, read data valid the cycle after mem_re.
  logic [63:0] bmem_d [64];
  logic [7:0]  bmem_t [64];
  logic [63:0] bwr = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      bmem_d[mem_addr[5:0]] <= mem_wdata;
      bmem_t[mem_addr[5:0]] <= mem_wtag;
      bwr[mem_addr[5:0]]    <= 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= bwr[mem_addr[5:0]] ? bmem_d[mem_addr[5:0]] : pat_d(int'(mem_addr[5:0]));
      mem_rtag  <= bwr[mem_addr[5:0]] ? bmem_t[mem_addr[5:0]] : pat_t(int'(mem_addr[5:0]));
    end
    n_re <= n_re + int'(mem_re);
    n_we <= n_we + int'(mem_we);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_re | mem_we) chk("re_we_excl", 64'(mem_re & mem_we), 64'd0);
      if (c_if.ack | d_if.ack) chk("ack_excl", 64'(c_if.ack & d_if.ack), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drv(input int p, input logic astb, input logic rd, input logic wr,
                     input logic [63:0] ad, input logic [7:0] tag);
    if (p == 0) begin
      c_if.astb = astb; c_if.rd = rd; c_if.wr = wr; c_if.ad = ad; c_if.tag = tag;
    end else begin
      d_if.astb = astb; d_if.rd = rd; d_if.wr = wr; d_if.ad = ad; d_if.tag = tag;
    end
  endtask

  task automatic quiet();
    drv(0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    quiet();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? c_if.ack : d_if.ack;
  endfunction
  function automatic logic busy_of(input int p);
    return (p == 0) ? c_if.busy : d_if.busy;
  endfunction
  function automatic logic [63:0] rdata_of(input int p);
    return (p == 0) ? c_if.rdata : d_if.rdata;
  endfunction
  function automatic logic [7:0] rtag_of(input int p);
    return (p == 0) ? c_if.rtag : d_if.rtag;
  endfunction

  // Uncontended read: astb+rd at N, mem_re at N+2, ack and data at N+4.
  task automatic rd_lat(input int p, input logic [63:0] ad, input logic [63:0] ed,
                        input logic [7:0] et, input string nm);
    drv(p, 1'b1, 1'b1, 1'b0, ad, 8'd0);
    tick();
    quiet();
    chk({nm, "_busy"}, 64'(busy_of(p)), 64'd1);
    tick();
    chk({nm, "_re"}, 64'(mem_re), 64'd1);
    chk({nm, "_addr"}, 64'(mem_addr), 64'(ad[19:0]));
    tick();
    chk({nm, "_re_pulse"}, 64'(mem_re), 64'd0);
    chk({nm, "_ack_early"}, 64'(ack_of(p)), 64'd0);
    tick();
    chk({nm, "_ack"}, 64'(ack_of(p)), 64'd1);
    chk({nm, "_rdata"}, rdata_of(p), ed);
    chk({nm, "_rtag"}, 64'(rtag_of(p)), 64'(et));
    tick();
    chk({nm, "_ack_pulse"}, 64'(ack_of(p)), 64'd0);
    chk({nm, "_busy_clr"}, 64'(busy_of(p)), 64'd0);
  endtask

  task automatic contend(input int first, input string nm);
    drv(0, 1'b1, 1'b1, 1'b0, 64'h10, 8'd0);
    drv(1, 1'b1, 1'b1, 1'b0, 64'h20, 8'd0);
    tick();
    quiet();
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("%s_c_ack_n%0d", nm, k), 64'(c_if.ack), 64'(k == ((first == 0) ? 4 : 8)));
      chk($sformatf("%s_d_ack_n%0d", nm, k), 64'(d_if.ack), 64'(k == ((first == 1) ? 4 : 8)));
      if (k < 9) tick();
    end
    chk({nm, "_c_rdata"}, c_if.rdata, pat_d(16));
    chk({nm, "_d_rdata"}, d_if.rdata, pat_d(32));
    chk({nm, "_d_rtag"}, 64'(d_if.rtag), 64'(pat_t(32)));
  endtask

  // Reference model: one outstanding request per port, memory as a plain array.
  logic [63:0] ref_d [64];
  logic [7:0]  ref_t [64];
  bit          ref_w [64];
  logic [63:0] m_addr [2];
  bit          m_out [2];
  bit          m_op [2];
  logic [63:0] m_ed [2];
  logic [7:0]  m_et [2];
  int          m_t0 [2];

  task automatic observe(input int p);
    int lat;
    if (ack_of(p)) begin
      chk($sformatf("rnd%0d_ack_expected", p), 64'(m_out[p]), 64'd1);
      lat = cyc - m_t0[p];
      if (m_op[p]) begin
        chk($sformatf("rnd%0d_wr_lat", p), 64'(lat >= 3 && lat <= 7), 64'd1);
      end else begin
        chk($sformatf("rnd%0d_rd_lat", p), 64'(lat >= 4 && lat <= 8), 64'd1);
        chk($sformatf("rnd%0d_rdata", p), rdata_of(p), m_ed[p]);
        chk($sformatf("rnd%0d_rtag", p), 64'(rtag_of(p)), 64'(m_et[p]));
      end
      m_out[p] = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd_addr(input int p);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[5] = (p == 1);
    return a;
  endfunction

  initial begin
    int lat;
    int re0, we0;
    logic [63:0] a, wd;
    logic [7:0] wt;
    int idx;
    int r;

    for (int i = 0; i < 64; i++) begin
      ref_d[i] = pat_d(i);
      ref_t[i] = pat_t(i);
      ref_w[i] = 1'b0;
    end
    quiet();
    do_reset();

    chk("rst_c_busy", 64'(c_if.busy), 64'd0);
    chk("rst_c_ack", 64'(c_if.ack), 64'd0);
    chk("rst_d_err", 64'(d_if.err), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_c_rdata", c_if.rdata, 64'd0);

    // Fresh reset: port 0 wins the first tie.
    contend(0, "tie0");

    // Port 0 write then read back.
    drv(0, 1'b1, 1'b0, 1'b0, 64'h12345, 8'd0);
    tick();
    drv(0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h35);
    tick();
    quiet();
    chk("wr_busy", 64'(c_if.busy), 64'd1);
    tick();
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_re", 64'(mem_re), 64'd0);
    chk("wr_addr", 64'(mem_addr), 64'h12345);
    chk("wr_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
    chk("wr_wtag", 64'(mem_wtag), 64'h35);
    tick();
    chk("wr_ack", 64'(c_if.ack), 64'd1);
    tick();
    chk("wr_ack_pulse", 64'(c_if.ack), 64'd0);
    ref_d[5] = 64'hDEAD_BEEF_0000_0001;
    ref_t[5] = 8'h35;
    ref_w[5] = 1'b1;
    rd_lat(0, 64'h12345, 64'hDEAD_BEEF_0000_0001, 8'h35, "rdback");

    // Port 0 was served last, so port 1 wins this tie.
    contend(1, "tie1");

    // Upper address bits are dropped.
    rd_lat(0, 64'hFFFF_FFFF_FFF1_2345, 64'hDEAD_BEEF_0000_0001, 8'h35, "hiaddr");

    // Port 1 re-requests in its ack cycle.
    drv(1, 1'b1, 1'b1, 1'b0, 64'h21, 8'd0);
    tick();
    quiet();
    tick();
    tick();
    tick();
    chk("ackrd_first_ack", 64'(d_if.ack), 64'd1);
    drv(1, 1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
    tick();
    quiet();
    chk("ackrd_busy", 64'(d_if.busy), 64'd1);
    chk("ackrd_err", 64'(d_if.err), 64'd0);
    lat = 1;
    while (!d_if.ack && lat < 10) begin
      tick();
      lat++;
    end
    chk("ackrd_lat", 64'(lat), 64'd4);
    chk("ackrd_rdata", d_if.rdata, pat_d(33));
    tick();

    // astb with wr: error, nothing reaches memory.
    do_reset();
    re0 = n_re;
    we0 = n_we;
    drv(0, 1'b1, 1'b0, 1'b1, 64'h40, 8'h01);
    tick();
    quiet();
    chk("err_astbwr_err", 64'(c_if.err), 64'd1);
    chk("err_astbwr_busy", 64'(c_if.busy), 64'd0);
    repeat (4) tick();
    chk("err_astbwr_noacc", 64'((n_re - re0) + (n_we - we0)), 64'd0);

    // rd while pending: error, first read still completes once.
    re0 = n_re;
    drv(1, 1'b1, 1'b1, 1'b0, 64'h22, 8'd0);
    tick();
    drv(1, 1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
    tick();
    quiet();
    chk("err_pend_err", 64'(d_if.err), 64'd1);
    tick();
    tick();
    chk("err_pend_ack", 64'(d_if.ack), 64'd1);
    chk("err_pend_rdata", d_if.rdata, pat_d(34));
    tick();
    tick();
    chk("err_pend_one_re", 64'(n_re - re0), 64'd1);
    chk("err_pend_busy", 64'(d_if.busy), 64'd0);
    chk("err_sticky", 64'(c_if.err), 64'd1);

    // rd with wr: error, nothing reaches memory.
    do_reset();
    chk("err_cleared", 64'(c_if.err), 64'd0);
    re0 = n_re;
    we0 = n_we;
    drv(0, 1'b0, 1'b1, 1'b1, 64'h44, 8'h02);
    tick();
    quiet();
    chk("err_rdwr_err", 64'(c_if.err), 64'd1);
    chk("err_rdwr_busy", 64'(c_if.busy), 64'd0);
    repeat (4) tick();
    chk("err_rdwr_noacc", 64'((n_re - re0) + (n_we - we0)), 64'd0);

    // Reset during CAPTURE abandons the read.
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 64'h10, 8'd0);
    tick();
    quiet();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rstcap_ack", 64'(c_if.ack), 64'd0);
    chk("rstcap_busy", 64'(c_if.busy), 64'd0);
    chk("rstcap_re", 64'(mem_re), 64'd0);
    chk("rstcap_we", 64'(mem_we), 64'd0);
    chk("rstcap_addr", 64'(mem_addr), 64'd0);
    chk("rstcap_rdata", c_if.rdata, 64'd0);
    reset = 1'b0;
    rd_lat(0, 64'h10, pat_d(16), pat_t(16), "rstcap_rd");

    // Random traffic; each port keeps to its own half of memory.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = rnd_addr(p);
      m_out[p] = 1'b0;
      drv(p, 1'b1, 1'b0, 1'b0, m_addr[p], 8'd0);
    end
    tick();
    quiet();
    for (int t = 0; t < 600; t++) begin
      for (int p = 0; p < 2; p++) begin
        observe(p);
        drv(p, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
        if (!m_out[p]) begin
          r = int'($urandom_range(0, 5));
          if (r == 1 || r == 4) begin
            a = rnd_addr(p);
            idx = int'(a[5:0]);
            drv(p, 1'b1, 1'b1, 1'b0, a, 8'd0);
            m_addr[p] = a;
            m_ed[p] = ref_w[idx] ? ref_d[idx] : pat_d(idx);
            m_et[p] = ref_w[idx] ? ref_t[idx] : pat_t(idx);
            m_op[p] = 1'b0;
            m_out[p] = 1'b1;
            m_t0[p] = cyc;
          end else if (r == 2) begin
            wd = {$urandom, $urandom};
            wt = 8'($urandom);
            idx = int'(m_addr[p][5:0]);
            drv(p, 1'b0, 1'b0, 1'b1, wd, wt);
            ref_d[idx] = wd;
            ref_t[idx] = wt;
            ref_w[idx] = 1'b1;
            m_op[p] = 1'b1;
            m_out[p] = 1'b1;
            m_t0[p] = cyc;
          end else if (r == 3) begin
            a = rnd_addr(p);
            drv(p, 1'b1, 1'b0, 1'b0, a, 8'd0);
            m_addr[p] = a;
          end
        end
      end
      tick();
    end
    quiet();
    for (int t = 0; t < 20 && (m_out[0] || m_out[1]); t++) begin
      observe(0);
      observe(1);
      tick();
    end
    chk("rnd_drained", 64'(m_out[0] | m_out[1]), 64'd0);
    chk("rnd_c_err", 64'(c_if.err), 64'd0);
    chk("rnd_d_err", 64'(d_if.err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
